led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
- Controller that sequences the team's LED pattern generator by driving its 2-bit mode select and enable.
- Plays a programmable playlist of up to 4 entries; each entry is a pattern mode plus a dwell time counted in generator update ticks.
- A manual override request can preempt the playlist at any time; the playlist resumes where it left off.
- Sits between the top-level input pins / config logic and the generator.

Parameters:
- PRESC_W, 4, prescaler width; one tick every 2^PRESC_W cycles, matching the generator's 16-cycle update.
- DWELL_W, 6, width of per-entry dwell field.
- LOOP, 1, 1 = wrap to entry 0 after the last entry; 0 = stop and pulse done.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  playlist write strobe
- cfg_addr  in  2  playlist entry index
- cfg_mode  in  2  pattern mode to store
- cfg_dwell  in  DWELL_W  dwell to store; entry lasts (dwell+1) ticks
- len  in  2  last entry index (entries 0..len); sampled on start
- start  in  1  start/restart pulse
- stop  in  1  stop pulse
- man_req  in  1  manual override request, level
- man_mode  in  2  override pattern mode
- gen_mode  out  2  mode select to generator
- gen_ena  out  1  enable to generator
- entry_idx  out  2  currently playing entry
- step_pulse  out  1  one-cycle pulse on each entry load
- ovr_active  out  1  override in effect
- busy  out  1  state != IDLE (RUN or override-from-RUN)
- done  out  1  one-cycle pulse at end of playlist when LOOP=0

Behaviour:
- All outputs are registered. Reset values: gen_mode=0, gen_ena=0, entry_idx=0, step_pulse=0, ovr_active=0, busy=0, done=0.
- Reset also clears playlist entries (mode 0, dwell 0), the prescaler, the dwell counter, the latched length and the saved state.
- Playlist: 4 x {mode[1:0], dwell[DWELL_W-1:0]}. cfg_we writes entry cfg_addr at the clock edge and is accepted in any state.
- A write to the playing entry takes effect only at that entry's next load; the active copy is latched at load.
- States: IDLE, RUN, OVR. OVR records its return state (IDLE or RUN).
- IDLE:
  - gen_ena=0, gen_mode holds its last value.
  - start -> RUN: len latched, entry 0 loaded, prescaler cleared, dwell_cnt = dwell[0], step_pulse=1.
  - gen_ena=1 and gen_mode=mode[0] appear in the cycle after the start edge.
- RUN:
  - Prescaler increments each cycle; tick = (prescaler == all ones).
  - On tick: if dwell_cnt==0, advance to the next entry; otherwise dwell_cnt decrements.
  - Advance from idx < latched len: load idx+1 and pulse step_pulse.
  - Advance from idx == len with LOOP=1: load entry 0 and pulse step_pulse.
  - Advance from idx == len with LOOP=0: go to IDLE, pulse done, gen_ena=0.
  - Resulting entry duration is exactly (dwell+1)*2^PRESC_W cycles.
  - start in RUN: restart at entry 0, re-latch len, clear prescaler.
  - stop -> IDLE.
- OVR:
  - Entered from IDLE or RUN when man_req=1.
  - gen_mode=man_mode, tracking each cycle with one register delay; gen_ena=1, ovr_active=1.
  - Prescaler and dwell_cnt are frozen.
  - When man_req falls, return to the saved state. RUN resumes the same entry with the remaining dwell and prescaler value, and gen_mode is restored to that entry's mode. IDLE returns with gen_ena=0.
  - stop during OVR sets the return state to IDLE.
  - start during OVR sets the return state to RUN at entry 0 (latched len, cleared prescaler); the start is applied on exit.
- Priority, same cycle: rst > man_req > stop > start > tick.
- A tick coinciding with man_req rising is discarded; the dwell counter does not move.
- len > 3 is impossible by width. entry_idx wraps 3 -> 0 only via the len rule.
- Reset mid-RUN or mid-OVR: outputs go to reset values immediately (asynchronous assert). The playlist is lost.

Decomposition:
- Shared package led_pkg:
  - mode constants MODE_COUNT=2'b00, MODE_SCAN=2'b01, MODE_LFSR=2'b10, MODE_ALT=2'b11;
  - sequencer state enum {SEQ_IDLE, SEQ_RUN, SEQ_OVR};
  - playlist entry struct/typedef.
- One natural sub-module: led_tick_prescaler. It is a PRESC_W-bit counter with clear and freeze inputs and a tick output.

Test Plan:
- Reset, then write entries 0..1 = {MODE_SCAN, dwell 0}, {MODE_ALT, dwell 1}; len=1, start. Expect step_pulse at cycle +1 with gen_mode=01; the switch to 11 after 16 cycles; back to 01 32 cycles later (LOOP=1); gen_ena=1 throughout.
- LOOP=0, single entry {MODE_LFSR, dwell 2}, len=0, start. Expect gen_mode=10 for exactly 48 cycles, then a one-cycle done pulse, gen_ena=0, busy=0.
- In RUN at entry 1, 5 cycles into its dwell, assert man_req with man_mode=00 for 40 cycles. Expect gen_mode=00 and ovr_active=1 during override; after release entry 1 resumes and completes its remaining 27 cycles.
- start and stop asserted in the same cycle from RUN -> IDLE, gen_ena=0. start alone in RUN -> entry_idx=0, step_pulse, prescaler restarted.
- cfg_we to the currently playing entry changing its mode. Expect gen_mode unchanged until that entry is reloaded on the next loop.
- Assert rst asynchronously mid-RUN. Expect all outputs at reset values before the next clk edge. After release plus start, the cleared playlist plays mode 00.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator and its sequencer.
package led_pkg;

  // Generator pattern modes
  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_SCAN  = 2'b01;
  localparam logic [1:0] MODE_LFSR  = 2'b10;
  localparam logic [1:0] MODE_ALT   = 2'b11;

  // Default dwell field width of a playlist entry
  localparam int unsigned LED_DWELL_W = 6;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_OVR
  } seq_state_e;

  // One playlist entry: generator mode plus dwell in update ticks (minus one)
  typedef struct packed {
    logic [1:0]             mode;
    logic [LED_DWELL_W-1:0] dwell;
  } led_entry_t;

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running tick prescaler: one tick every 2^PRESC_W enabled cycles.
module led_tick_prescaler #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_freeze,
  output logic o_tick
);

  logic [PRESC_W-1:0] r_cnt;

  // Counter: clear wins over freeze; freeze holds the value for later resume
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (!i_freeze) begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

  assign o_tick = (r_cnt == {PRESC_W{1'b1}});

endmodule

// File: rtl/led_pattern_sequencer.sv
// Playlist sequencer driving the LED pattern generator's mode select and enable,
// with a manual override that preempts and later resumes the playlist.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int unsigned PRESC_W = 4,
  parameter int unsigned DWELL_W = LED_DWELL_W,
  parameter int unsigned LOOP    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [1:0]         i_cfg_addr,
  input  logic [1:0]         i_cfg_mode,
  input  logic [DWELL_W-1:0] i_cfg_dwell,
  input  logic [1:0]         i_len,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_man_req,
  input  logic [1:0]         i_man_mode,
  output logic [1:0]         o_gen_mode,
  output logic               o_gen_ena,
  output logic [1:0]         o_entry_idx,
  output logic               o_step_pulse,
  output logic               o_ovr_active,
  output logic               o_busy,
  output logic               o_done
);

  // Playlist storage
  logic [1:0]         r_pl_mode  [4];
  logic [DWELL_W-1:0] r_pl_dwell [4];

  // Sequencer state
  seq_state_e         r_state;
  seq_state_e         r_ret;        // state to return to when override ends
  logic               r_pend;       // start seen during override, applied on exit
  logic [1:0]         r_len;
  logic [1:0]         r_act_mode;   // active copy of the playing entry's mode
  logic [DWELL_W-1:0] r_dwell_cnt;

  // Registered outputs
  logic [1:0] r_gen_mode;
  logic       r_gen_ena;
  logic [1:0] r_entry_idx;
  logic       r_step_pulse;
  logic       r_ovr_active;
  logic       r_busy;
  logic       r_done;

  // Decode
  logic       w_tick;
  logic       w_presc_clear;
  logic       w_presc_freeze;
  logic       w_load;
  logic [1:0] w_load_idx;
  logic       w_len_latch;
  seq_state_e w_ret_next;
  logic       w_pend_next;

  led_tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_presc_clear),
    .i_freeze (w_presc_freeze),
    .o_tick   (w_tick)
  );

  // Prescaler only runs in RUN; a man_req cycle freezes it so its tick is discarded
  assign w_presc_freeze = !((r_state == SEQ_RUN) && !i_man_req);

  // Entry-load, prescaler-clear and override return decisions
  always_comb begin
    w_load        = 1'b0;
    w_load_idx    = 2'd0;
    w_presc_clear = 1'b0;
    w_len_latch   = 1'b0;
    w_ret_next    = r_ret;
    w_pend_next   = r_pend;
    if (i_stop) begin
      w_ret_next  = SEQ_IDLE;
      w_pend_next = 1'b0;
    end else if (i_start) begin
      w_ret_next  = SEQ_RUN;
      w_pend_next = 1'b1;
    end
    unique case (r_state)
      SEQ_IDLE: begin
        if (!i_man_req && i_start) begin
          w_load        = 1'b1;
          w_presc_clear = 1'b1;
          w_len_latch   = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (!i_man_req && !i_stop) begin
          if (i_start) begin
            w_load        = 1'b1;
            w_presc_clear = 1'b1;
            w_len_latch   = 1'b1;
          end else if (w_tick && (r_dwell_cnt == '0)) begin
            if (r_entry_idx != r_len) begin
              w_load     = 1'b1;
              w_load_idx = r_entry_idx + 2'd1;
            end else if (LOOP != 0) begin
              w_load = 1'b1;
            end
          end
        end
      end
      SEQ_OVR: begin
        w_len_latch = i_start && !i_stop;
        if (!i_man_req && (w_ret_next == SEQ_RUN) && w_pend_next) begin
          w_load        = 1'b1;
          w_presc_clear = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Playlist writes are accepted in any state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) begin
        r_pl_mode[i]  <= MODE_COUNT;
        r_pl_dwell[i] <= '0;
      end
    end else if (i_cfg_we) begin
      r_pl_mode[i_cfg_addr]  <= i_cfg_mode;
      r_pl_dwell[i_cfg_addr] <= i_cfg_dwell;
    end
  end

  // Main FSM with registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= SEQ_IDLE;
      r_ret        <= SEQ_IDLE;
      r_pend       <= 1'b0;
      r_len        <= 2'd0;
      r_act_mode   <= MODE_COUNT;
      r_dwell_cnt  <= '0;
      r_gen_mode   <= MODE_COUNT;
      r_gen_ena    <= 1'b0;
      r_entry_idx  <= 2'd0;
      r_step_pulse <= 1'b0;
      r_ovr_active <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      r_done       <= 1'b0;
      if (w_len_latch) begin
        r_len <= i_len;
      end
      if (w_load) begin
        r_state      <= SEQ_RUN;
        r_pend       <= 1'b0;
        r_entry_idx  <= w_load_idx;
        r_act_mode   <= r_pl_mode[w_load_idx];
        r_dwell_cnt  <= r_pl_dwell[w_load_idx];
        r_gen_mode   <= r_pl_mode[w_load_idx];
        r_gen_ena    <= 1'b1;
        r_step_pulse <= 1'b1;
        r_ovr_active <= 1'b0;
        r_busy       <= 1'b1;
      end else begin
        unique case (r_state)
          SEQ_IDLE: begin
            if (i_man_req) begin
              r_state      <= SEQ_OVR;
              r_ret        <= SEQ_IDLE;
              r_pend       <= 1'b0;
              r_gen_mode   <= i_man_mode;
              r_gen_ena    <= 1'b1;
              r_ovr_active <= 1'b1;
              r_busy       <= 1'b0;
            end
          end
          SEQ_RUN: begin
            if (i_man_req) begin
              r_state      <= SEQ_OVR;
              r_ret        <= SEQ_RUN;
              r_pend       <= 1'b0;
              r_gen_mode   <= i_man_mode;
              r_ovr_active <= 1'b1;
            end else if (i_stop) begin
              r_state   <= SEQ_IDLE;
              r_gen_ena <= 1'b0;
              r_busy    <= 1'b0;
            end else if (w_tick) begin
              if (r_dwell_cnt == '0) begin
                // Only reachable at the last entry with looping disabled
                r_state   <= SEQ_IDLE;
                r_gen_ena <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
              end
            end
          end
          SEQ_OVR: begin
            if (i_man_req) begin
              r_gen_mode <= i_man_mode;
              r_ret      <= w_ret_next;
              r_pend     <= w_pend_next;
              r_busy     <= (w_ret_next == SEQ_RUN);
            end else if (w_ret_next == SEQ_RUN) begin
              // Resume the interrupted entry with its frozen dwell and prescaler
              r_state      <= SEQ_RUN;
              r_gen_mode   <= r_act_mode;
              r_gen_ena    <= 1'b1;
              r_ovr_active <= 1'b0;
              r_busy       <= 1'b1;
            end else begin
              r_state      <= SEQ_IDLE;
              r_pend       <= 1'b0;
              r_gen_ena    <= 1'b0;
              r_ovr_active <= 1'b0;
              r_busy       <= 1'b0;
            end
          end
          default: r_state <= SEQ_IDLE;
        endcase
      end
    end
  end

  assign o_gen_mode   = r_gen_mode;
  assign o_gen_ena    = r_gen_ena;
  assign o_entry_idx  = r_entry_idx;
  assign o_step_pulse = r_step_pulse;
  assign o_ovr_active = r_ovr_active;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
